// File: rtl/tohost_mmio.sv
// Memory-mapped host mailbox: N_CH byte-writable channels, CTRL word, LED select.
// Define TOHOST_DONE_EN to enable tohost end-of-test detection and CLR_DONE.
module tohost_mmio #(
    parameter int unsigned N_CH      = 4,
    parameter logic [31:0] BASE_ADDR = 32'h8000_1000,
    parameter int unsigned LED_W     = 16
) (
    input  logic             i_clk,
    input  logic             rst,
    input  logic             i_cs,
    input  logic             i_wr_en,
    input  logic [3:0]       i_b_en,
    input  logic [31:0]      i_wr_data,
    input  logic [31:0]      i_addr,
    output logic             o_hit,
    output logic             o_ack,
    output logic [31:0]      o_rd_data,
    output logic [LED_W-1:0] o_led,
    output logic             o_done,
    output logic             o_pass,
    output logic [30:0]      o_code
);

    localparam logic [31:0] WIN_BYTES = 32'(4 * (N_CH + 1));
    localparam logic [4:0]  CTRL_W    = 5'(N_CH);

    typedef enum logic {
        IDLE,
        ACK
    } state_t;

    state_t state, state_nxt;
    logic accept;
    logic wr;

    logic [31:0] offset;
    logic [4:0]  word;

    logic [31:0]      ch [N_CH];
    logic [3:0]       led_sel;
    logic [31:0]      rd_data;
    logic [31:0]      rd_mux;
    logic [LED_W-1:0] led_mux;

    // Unsigned offset wraps below BASE_ADDR, so one compare covers both ends
    assign offset = i_addr - BASE_ADDR;
    assign o_hit  = offset < WIN_BYTES;
    assign word   = offset[6:2];

    always_ff @(posedge i_clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        o_ack     = 1'b0;
        unique case (state)
            IDLE: begin
                if (i_cs && o_hit) begin
                    accept    = 1'b1;
                    state_nxt = ACK;
                end
            end
            ACK: begin
                o_ack     = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign wr = accept && i_wr_en;

    always_comb begin
        rd_mux = '0;
        if (word == CTRL_W) rd_mux = {28'd0, led_sel};
        for (int k = 0; k < int'(N_CH); k++) begin
            if (word == 5'(k)) rd_mux = ch[k];
        end
    end

    always_comb begin
        led_mux = '0;
        for (int k = 0; k < int'(N_CH); k++) begin
            if (led_sel == 4'(k)) led_mux = ch[k][LED_W-1:0];
        end
    end

    assign o_led     = led_mux;
    assign o_rd_data = rd_data;

    always_ff @(posedge i_clk) begin
        if (!rst) begin
            for (int k = 0; k < int'(N_CH); k++) ch[k] <= '0;
            led_sel <= '0;
            rd_data <= '0;
        end else if (accept) begin
            rd_data <= rd_mux;
            if (wr) begin
                for (int k = 0; k < int'(N_CH); k++) begin
                    for (int b = 0; b < 4; b++) begin
                        if (word == 5'(k) && i_b_en[b])
                            ch[k][8*b +: 8] <= i_wr_data[8*b +: 8];
                    end
                end
                if (word == CTRL_W && i_b_en[0]) led_sel <= i_wr_data[3:0];
            end
        end
    end

`ifdef TOHOST_DONE_EN
    logic        done;
    logic [30:0] code;
    logic        clr_hit;
    logic        det_hit;

    assign clr_hit = wr && word == CTRL_W && i_b_en[1] && i_wr_data[8];
    // First code wins: detection is blocked while done is already set
    assign det_hit = wr && word == 5'd0 && i_b_en == 4'hF
                     && i_wr_data[0] && !done;

    always_ff @(posedge i_clk) begin
        if (!rst) begin
            done <= 1'b0;
            code <= '0;
        end else if (clr_hit) begin
            done <= 1'b0;
            code <= '0;
        end else if (det_hit) begin
            done <= 1'b1;
            code <= i_wr_data[31:1];
        end
    end

    assign o_done = done;
    assign o_code = code;
    assign o_pass = done && code == '0;
`else
    assign o_done = 1'b0;
    assign o_code = '0;
    assign o_pass = 1'b0;
`endif

endmodule

// File: tb/tb_tohost_mmio.sv
// Directed self-checking bench for tohost_mmio (N_CH=4, LED_W=16).
// Done-flag expectations follow whether TOHOST_DONE_EN is defined.
module tb_tohost_mmio;

    logic        i_clk;
    logic        rst;
    logic        i_cs;
    logic        i_wr_en;
    logic [3:0]  i_b_en;
    logic [31:0] i_wr_data;
    logic [31:0] i_addr;
    logic        o_hit;
    logic        o_ack;
    logic [31:0] o_rd_data;
    logic [15:0] o_led;
    logic        o_done;
    logic        o_pass;
    logic [30:0] o_code;

    int n_cmp = 0;
    int n_bad = 0;

`ifdef TOHOST_DONE_EN
    localparam bit DEN = 1'b1;
`else
    localparam bit DEN = 1'b0;
`endif

    tohost_mmio #(
        .N_CH     (4),
        .BASE_ADDR(32'h8000_1000),
        .LED_W    (16)
    ) dut (
        .i_clk    (i_clk),
        .rst      (rst),
        .i_cs     (i_cs),
        .i_wr_en  (i_wr_en),
        .i_b_en   (i_b_en),
        .i_wr_data(i_wr_data),
        .i_addr   (i_addr),
        .o_hit    (o_hit),
        .o_ack    (o_ack),
        .o_rd_data(o_rd_data),
        .o_led    (o_led),
        .o_done   (o_done),
        .o_pass   (o_pass),
        .o_code   (o_code)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // One full access: drive, accept edge, ACK cycle, back to IDLE
    task automatic xfer(input logic wr, input logic [31:0] addr,
                        input logic [31:0] data, input logic [3:0] ben,
                        output logic [31:0] rd);
        @(negedge i_clk);
        i_cs      = 1'b1;
        i_wr_en   = wr;
        i_addr    = addr;
        i_wr_data = data;
        i_b_en    = ben;
        @(posedge i_clk);
        #1;
        i_cs = 1'b0;
        chk("ack_pulse", 32'(o_ack), 32'd1);
        rd = o_rd_data;
        @(posedge i_clk);
        #1;
        chk("ack_drop", 32'(o_ack), 32'd0);
    endtask

    task automatic wr32(input logic [31:0] addr, input logic [31:0] data,
                        input logic [3:0] ben);
        logic [31:0] rd;
        xfer(1'b1, addr, data, ben, rd);
    endtask

    task automatic rd32(input logic [31:0] addr, output logic [31:0] rd);
        xfer(1'b0, addr, 32'h0, 4'h0, rd);
    endtask

    task automatic chk_done(input string tag, input logic d,
                            input logic p, input logic [30:0] c);
        chk({tag, "_done"}, 32'(o_done), 32'(d & DEN));
        chk({tag, "_pass"}, 32'(o_pass), 32'(p & DEN));
        chk({tag, "_code"}, 32'(o_code), DEN ? 32'(c) : 32'd0);
    endtask

    logic [31:0] rd;

    initial begin
        rst       = 1'b0;
        i_cs      = 1'b0;
        i_wr_en   = 1'b0;
        i_b_en    = 4'h0;
        i_wr_data = 32'h0;
        i_addr    = 32'h0;
        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        chk("rst_ack", 32'(o_ack), 32'd0);
        chk("rst_rd", o_rd_data, 32'd0);
        chk("rst_led", 32'(o_led), 32'd0);
        chk_done("rst", 1'b0, 1'b0, 31'd0);
        rst = 1'b1;

        // Channel 0 write drives LEDs; bit 0 set also triggers detect if enabled
        wr32(32'h8000_1000, 32'h0000_A5A5, 4'hF);
        chk("led_a5a5", 32'(o_led), 32'h0000_A5A5);
        chk_done("a5a5", 1'b1, 1'b0, 31'h52D2);
        wr32(32'h8000_1010, 32'h0000_0100, 4'hF);
        chk_done("clr0", 1'b0, 1'b0, 31'd0);

        // Partial byte write
        wr32(32'h8000_1008, 32'h1234_5678, 4'b0101);
        rd32(32'h8000_1008, rd);
        chk("ch2_bytes", rd, 32'h0034_0078);

        // LED select
        wr32(32'h8000_1010, 32'h0000_0002, 4'hF);
        chk("led_sel2", 32'(o_led), 32'h0000_0078);
        wr32(32'h8000_1010, 32'h0000_0007, 4'hF);
        chk("led_sel7", 32'(o_led), 32'h0);
        rd32(32'h8000_1010, rd);
        chk("ctrl_rd7", rd, 32'h0000_0007);
        wr32(32'h8000_1010, 32'h0000_0003, 4'b0010);
        rd32(32'h8000_1010, rd);
        chk("ctrl_b1only", rd, 32'h0000_0007);

        // Zero byte-enable write is acked but ignored
        wr32(32'h8000_1004, 32'hDEAD_BEEF, 4'hF);
        wr32(32'h8000_1004, 32'h0000_0000, 4'h0);
        rd32(32'h8000_1004, rd);
        chk("ben0", rd, 32'hDEAD_BEEF);

        // End-of-test sequence
        wr32(32'h8000_1000, 32'h0000_0001, 4'hF);
        chk_done("det1", 1'b1, 1'b1, 31'd0);
        wr32(32'h8000_1000, 32'h0000_0007, 4'hF);
        chk_done("det_hold", 1'b1, 1'b1, 31'd0);
        rd32(32'h8000_1000, rd);
        chk("ch0_upd", rd, 32'h0000_0007);
        wr32(32'h8000_1010, 32'h0000_0100, 4'hF);
        chk_done("clr", 1'b0, 1'b0, 31'd0);
        wr32(32'h8000_1000, 32'h0000_0001, 4'b0111);
        chk_done("det_partial", 1'b0, 1'b0, 31'd0);
        wr32(32'h8000_1000, 32'h0000_0007, 4'hF);
        chk_done("det7", 1'b1, 1'b0, 31'd3);

        // Window boundaries
        @(negedge i_clk);
        i_addr = 32'h8000_1013;
        #1 chk("hit_top", 32'(o_hit), 32'd1);
        i_addr = 32'h8000_1014;
        #1 chk("hit_above", 32'(o_hit), 32'd0);
        i_addr = 32'h8000_0FFC;
        #1 chk("hit_below", 32'(o_hit), 32'd0);

        // Out-of-window request held high
        i_addr    = 32'h8000_2000;
        i_wr_en   = 1'b1;
        i_b_en    = 4'hF;
        i_wr_data = 32'hFFFF_FFFF;
        i_cs      = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge i_clk);
            chk("oow_hit", 32'(o_hit), 32'd0);
            chk("oow_ack", 32'(o_ack), 32'd0);
        end
        i_cs = 1'b0;
        rd32(32'h8000_1000, rd);
        chk("oow_ch0", rd, 32'h0000_0007);

        // Reset asserted during ACK
        wr32(32'h8000_1010, 32'h0000_0003, 4'h1);
        @(negedge i_clk);
        i_cs      = 1'b1;
        i_wr_en   = 1'b1;
        i_addr    = 32'h8000_100C;
        i_wr_data = 32'hCAFE_F00D;
        i_b_en    = 4'hF;
        @(posedge i_clk);
        #1;
        i_cs = 1'b0;
        chk("rack_ack", 32'(o_ack), 32'd1);
        chk("rack_led", 32'(o_led), 32'h0000_F00D);
        rst = 1'b0;
        @(posedge i_clk);
        #1;
        chk("rack_ack0", 32'(o_ack), 32'd0);
        chk("rack_led0", 32'(o_led), 32'd0);
        chk_done("rack", 1'b0, 1'b0, 31'd0);
        rst = 1'b1;
        for (int k = 0; k < 5; k++) begin
            rd32(32'h8000_1000 + 32'(4 * k), rd);
            chk("rack_clr", rd, 32'h0);
        end

        // Reset asserted on an accepting edge
        @(negedge i_clk);
        rst       = 1'b0;
        i_cs      = 1'b1;
        i_wr_en   = 1'b1;
        i_addr    = 32'h8000_1008;
        i_wr_data = 32'h0000_0055;
        i_b_en    = 4'hF;
        @(posedge i_clk);
        #1;
        i_cs = 1'b0;
        rst  = 1'b1;
        chk("racc_ack", 32'(o_ack), 32'd0);
        rd32(32'h8000_1008, rd);
        chk("racc_ch2", rd, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
